instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_if.sv | 26 ++
 rtl/instr_fetch_queue.sv | 56 +++++
 2 files changed

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch-side handshake and head-of-queue bus for the instruction fetch queue.
interface instr_fetch_queue_if #(
    parameter int DEPTH_BITS = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic                  flush;
    logic                  deq_stall;
    logic                  out_valid;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DEPTH_BITS:0]   count;
    logic                  overflow;
    modport master (
        output in_valid, in_data, in_pc, flush, deq_stall,
        input  out_valid, out_full, out_data, out_pc, count, overflow
    );
    modport slave (
        input  in_valid, in_data, in_pc, flush, deq_stall,
        output out_valid, out_full, out_data, out_pc, count, overflow
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: circular buffer of {pc, data} fetched instructions between i-cache and decode.
module instr_fetch_queue #(
    parameter int DEPTH      = 8,
    parameter int DEPTH_BITS = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_fetch_queue_if.slave   bus
);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    logic [EW-1:0]         r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_head;
    logic [DEPTH_BITS-1:0] r_tail;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_overflow;
    logic                  w_valid;
    logic                  w_full;
    logic                  w_enq;
    logic                  w_deq;
    logic [EW-1:0]         w_head;
    always_comb begin
        w_valid = r_count != '0;
        w_full  = r_count == (DEPTH_BITS+1)'(DEPTH);
        w_enq   = bus.in_valid & ~w_full & ~bus.flush;
        w_deq   = w_valid & ~bus.deq_stall & ~bus.flush;
        w_head  = w_valid ? r_mem[r_head] : '0;
    end
    assign bus.out_valid             = w_valid;
    assign bus.out_full              = w_full;
    assign {bus.out_pc, bus.out_data} = w_head;
    assign bus.count                 = r_count;
    assign bus.overflow              = r_overflow;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            r_count <= r_count + (DEPTH_BITS+1)'(w_enq) - (DEPTH_BITS+1)'(w_deq);
            // a write offered while full is dropped even if a dequeue frees a slot this cycle
            if (bus.in_valid & w_full) r_overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_enq & rst_n) r_mem[r_tail] <= {bus.in_pc, bus.in_data};
    end
endmodule
